// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI bus parallel-port target: FSM states and
// the bus addresses of the port registers.
package mpi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StRdDrive,
    StRdRply,
    StWrRply,
    StWaitEnd
  } mpi_state_e;

  localparam logic [15:0] PORT_DATA_ADDR = 16'o177714;
  localparam logic [15:0] PORT_RDBK_ADDR = 16'o177716;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/mpi_sync_pipe.sv
// Parameterized flop chain. Used as a synchronizer for the bus strobes and
// as a matching-depth delay line for nAD so data stays aligned with them.
module mpi_sync_pipe
  import mpi_pkg::*;
#(
  parameter int unsigned Stages = DEFAULT_SYNC_STAGES,
  parameter int unsigned Width = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] pipe_q [Stages];
  logic [Width-1:0] pipe_d [Stages];

  always_comb begin
    pipe_d[0] = d_i;
    for (int i = 1; i < Stages; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) begin
        pipe_q[i] <= ResetVal;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q_o = pipe_q[Stages-1];

endmodule

// File: rtl/mpi_port_target.sv
// MPI bus target for the parallel user port: decodes the address phase,
// serves reads of the input pins / readback register, latches writes.
module mpi_port_target
  import mpi_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = PORT_DATA_ADDR,
  parameter int unsigned RPLY_DELAY  = 2,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] nAD_i,
  output logic [15:0] nAD_o,
  output logic        nAD_oe,
  input  logic        nSYNC,
  input  logic        nDIN,
  input  logic        nDOUT,
  input  logic        nWTBT,
  output logic        nRPLY,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic        port_strobe
);

  localparam logic [15:0] RdbkAddr = BASE_ADDR + 16'd2;
  localparam logic [3:0]  CntLast  = 4'(RPLY_DELAY - 1);

  logic [3:0]  strb_s;
  logic [15:0] nad_s;
  logic        nsync_s, ndin_s, ndout_s, nwtbt_s;

  mpi_sync_pipe #(
    .Stages   (SYNC_STAGES),
    .Width    (4),
    .ResetVal (4'hF)
  ) u_strb_sync (
    .clk_i  (clk),
    .rst_ni (nRST),
    .d_i    ({nSYNC, nDIN, nDOUT, nWTBT}),
    .q_o    (strb_s)
  );

  mpi_sync_pipe #(
    .Stages   (SYNC_STAGES),
    .Width    (16),
    .ResetVal (16'hFFFF)
  ) u_nad_pipe (
    .clk_i  (clk),
    .rst_ni (nRST),
    .d_i    (nAD_i),
    .q_o    (nad_s)
  );

  assign {nsync_s, ndin_s, ndout_s, nwtbt_s} = strb_s;

  mpi_state_e  state_q, state_d;
  logic [2:0]  prev_q, prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rply_q, rply_d;
  logic        oe_q, oe_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] port_out_q, port_out_d;
  logic        strobe_q, strobe_d;
  logic        sel_rdbk_q, sel_rdbk_d;
  logic        addr0_q, addr0_d;

  logic [15:0] addr;
  logic        sync_fall, din_fall, dout_fall;
  logic        release_now;

  assign addr      = ~nad_s;
  assign sync_fall = prev_q[2] & ~nsync_s;
  assign din_fall  = prev_q[1] & ~ndin_s;
  assign dout_fall = prev_q[0] & ~ndout_s;

  always_comb begin
    state_d    = state_q;
    prev_d     = {nsync_s, ndin_s, ndout_s};
    cnt_d      = cnt_q;
    rply_d     = rply_q;
    oe_d       = oe_q;
    rd_data_d  = rd_data_q;
    port_out_d = port_out_q;
    strobe_d   = 1'b0;
    sel_rdbk_d = sel_rdbk_q;
    addr0_d    = addr0_q;

    if (state_q != StIdle && nsync_s) begin
      // Master dropped nSYNC: abandon whatever is in flight.
      state_d = StIdle;
      rply_d  = 1'b0;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sync_fall) begin
            addr0_d = addr[0];
            if (addr[15:1] == BASE_ADDR[15:1]) begin
              sel_rdbk_d = 1'b0;
              state_d    = StSel;
            end else if (addr[15:1] == RdbkAddr[15:1]) begin
              sel_rdbk_d = 1'b1;
              state_d    = StSel;
            end else begin
              state_d = StWaitEnd;
            end
          end
        end
        StSel: begin
          if (!ndin_s && !ndout_s) begin
            state_d = StWaitEnd;
          end else if (din_fall) begin
            rd_data_d = sel_rdbk_q ? port_out_q : port_in;
            oe_d      = 1'b1;
            cnt_d     = '0;
            state_d   = StRdDrive;
          end else if (dout_fall) begin
            if (!sel_rdbk_q) begin
              strobe_d = 1'b1;
              if (nwtbt_s) begin
                port_out_d = addr;
              end else if (addr0_q) begin
                port_out_d[15:8] = addr[7:0];
              end else begin
                port_out_d[7:0] = addr[7:0];
              end
            end
            cnt_d   = '0;
            state_d = StWrRply;
          end
        end
        StRdDrive: begin
          if (ndin_s) begin
            oe_d    = 1'b0;
            state_d = StWaitEnd;
          end else if (cnt_q == CntLast) begin
            rply_d  = 1'b1;
            state_d = StRdRply;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StRdRply: begin
          if (ndin_s) begin
            rply_d  = 1'b0;
            oe_d    = 1'b0;
            state_d = StWaitEnd;
          end
        end
        StWrRply: begin
          if (!rply_q) begin
            if (cnt_q == CntLast) begin
              rply_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (ndout_s) begin
            rply_d  = 1'b0;
            state_d = StWaitEnd;
          end
        end
        StWaitEnd: begin
          state_d = StWaitEnd;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q    <= StIdle;
      prev_q     <= 3'b111;
      cnt_q      <= '0;
      rply_q     <= 1'b0;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      port_out_q <= '0;
      strobe_q   <= 1'b0;
      sel_rdbk_q <= 1'b0;
      addr0_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      rply_q     <= rply_d;
      oe_q       <= oe_d;
      rd_data_q  <= rd_data_d;
      port_out_q <= port_out_d;
      strobe_q   <= strobe_d;
      sel_rdbk_q <= sel_rdbk_d;
      addr0_q    <= addr0_d;
    end
  end

  // Strobe release drops nRPLY and the data drive in the same cycle the
  // synced strobe rises, rather than one edge later.
  always_comb begin
    release_now = nsync_s
                | ((state_q == StRdRply) & ndin_s)
                | ((state_q == StWrRply) & ndout_s);
  end

  assign nRPLY       = ~(rply_q & ~release_now);
  assign nAD_oe      = oe_q & ~ndin_s & ~nsync_s;
  assign nAD_o       = ~rd_data_q;
  assign port_out    = port_out_q;
  assign port_strobe = strobe_q;

endmodule

// File: doc/mpi_port_target.md
Name: mpi_port_target

Overview:
- Synthesizable, clocked target (responder) on the МПИ (Q-bus style, active-low multiplexed) bus.
- Implements the parallel user port (УП) as a real bus slave: decodes the address phase, returns the input-pin register on reads, latches the output register on writes, and drives the nRPLY handshake.
- Sits between the CPU bus (nAD/nSYNC/nDIN/nDOUT/nWTBT) and the XT5 connector pins.
- Replaces the ad-hoc strobe/RC-delay glue with a cycle-accurate responder.

Parameters:
- BASE_ADDR, 16'o177714, word address of the port data register; BASE_ADDR+2 is the readback register.
- RPLY_DELAY, 2, clock cycles from data drive/latch to nRPLY assertion (range 1..15).
- SYNC_STAGES, 2, depth of the input synchronizer and of the aligned nAD delay pipeline (≥2).

Ports:
- clk  in  1  system clock
- nRST  in  1  synchronous active-low reset
- nAD_i  in  16  bus address/data as seen on the wire (inverted logic)
- nAD_o  out  16  inverted data to drive during reads
- nAD_oe  out  1  1 = drive nAD_o onto the bus (top level makes the tristate)
- nSYNC  in  1  address strobe, active low
- nDIN  in  1  read strobe, active low
- nDOUT  in  1  write strobe, active low
- nWTBT  in  1  write/byte qualifier, active low
- nRPLY  out  1  reply, active low (top level makes it open-drain)
- port_in  in  16  XT5 input pins (asynchronous)
- port_out  out  16  output register to XT5
- port_strobe  out  1  one-cycle pulse after each write to the data register

Behaviour:
- Reset (nRST=0 at posedge clk): nRPLY=1, nAD_oe=0, nAD_o=16'hFFFF, port_out=0, port_strobe=0, input register=0, state IDLE, synchronizers to 1. Reset asserted mid-cycle aborts the cycle at the same edge.
- Input alignment:
  - nSYNC, nDIN, nDOUT and nWTBT pass through a SYNC_STAGES flop chain.
  - nAD_i passes through an equal-depth plain delay pipeline, so sampled address/data stay aligned with the synchronized strobes.
  - Edges are detected on the synchronized signals.
- State machine: IDLE, SEL, RD_DRIVE, RD_RPLY, WR_RPLY, WAIT_END.
  - IDLE → (synced nSYNC fall):
    - addr = ~nAD_d.
    - If addr[15:1] equals BASE_ADDR[15:1] or (BASE_ADDR+2)[15:1]: latch addr and byte_cyc = ~nWTBT_d, then go to SEL.
    - Otherwise go to WAIT_END; never reply or drive.
  - SEL → (nDIN fall):
    - Capture input register <= port_in.
    - nAD_o <= ~data, where data = input register for BASE and port_out for BASE+2.
    - nAD_oe=1 in the following cycle; go to RD_DRIVE.
  - SEL → (nDOUT fall), writes to BASE only:
    - Word (nWTBT_d=1): port_out <= ~nAD_d.
    - Byte (nWTBT_d=0): updates [7:0] if addr[0]=0, else [15:8] from ~nAD_d[7:0]. Byte lane data is always on the low byte.
    - port_strobe=1 for one cycle; go to WR_RPLY.
    - Writes to BASE+2 are replied but change nothing and give no strobe.
  - RD_DRIVE: count RPLY_DELAY cycles, then nRPLY=0 → RD_RPLY.
  - WR_RPLY: count RPLY_DELAY cycles from the latch, then nRPLY=0; hold until nDOUT rises.
  - nDIN/nDOUT rise (synced) while replying: nRPLY=1 and nAD_oe=0 in the same cycle → WAIT_END.
  - WAIT_END → IDLE on synced nSYNC high.
- Abort: nSYNC high in any state forces nRPLY=1, nAD_oe=0 and IDLE at the next edge. A pending port_strobe still completes, and port_out keeps any already-latched write.
- nDIN and nDOUT low in the same synced cycle while in SEL is a protocol error: no drive, no reply, go to WAIT_END.
- nAD_oe is never 1 while synced nDIN is high. nRPLY is never 0 outside an active selected cycle.
- Back-to-back cycles are supported: a new nSYNC fall is accepted only after IDLE has been reached.

Decomposition:
- Shared package mpi_pkg holds:
  - the state enum;
  - the address constants PORT_DATA_ADDR = 16'o177714 and PORT_RDBK_ADDR = 16'o177716;
  - the default SYNC_STAGES.
- One sub-module, mpi_sync_pipe: a parameterized SYNC_STAGES-deep flop chain, instantiated for the 4 strobes (reset to 1) and for the 16-bit nAD (reset to 16'hFFFF).

Test Plan:
- Word write 16'o052525 to 177714, RPLY_DELAY=2:
  - port_out = 16'o052525; port_strobe high exactly 1 cycle.
  - nRPLY falls 2 cycles after the latch and rises ≤1+SYNC_STAGES cycles after nDOUT rises.
- Read of 177714 with port_in=16'h1234:
  - Bus sees ~nAD = 16'h1234 before nRPLY falls.
  - nAD_oe drops in the same cycle nRPLY rises.
  - Changing port_in to 16'hFFFF mid-cycle does not alter the returned value.
- Byte writes (nWTBT low) to 177715 with data 8'hA5, then to 177714 with data 8'h3C, starting from port_out=0 → port_out = 16'hA53C.
- Read of 177716 after the writes above → 16'hA53C; write to 177716 → reply given, port_out unchanged, no strobe.
- Cycle to 177710 (unselected) → nRPLY stays 1 and nAD_oe stays 0 for the whole cycle.
- Abort and reset:
  - nSYNC released during RD_RPLY → nRPLY=1, nAD_oe=0, state IDLE within SYNC_STAGES+1 cycles.
  - nRST=0 mid-write → all outputs at reset values after one edge.
